// File: rtl/axis_pkt_arbiter_if.sv
// Bundle of the N_SRC input streams and the single shared output stream.
// Latency/backpressure: none here, wires only; the arbiter defines timing.
// Ports: s_axis_* (per-source valid/ready/data/keep/last), m_axis_* (shared output + dest tag).
interface axis_pkt_arbiter_if #(
    parameter int N_SRC     = 4,
    parameter int DATA_BITS = 512,
    parameter int SRC_BITS  = (N_SRC > 1) ? $clog2(N_SRC) : 1
);
    logic [N_SRC-1:0]             s_axis_valid;
    logic [N_SRC-1:0]             s_axis_ready;
    logic [N_SRC*DATA_BITS-1:0]   s_axis_data;
    logic [N_SRC*DATA_BITS/8-1:0] s_axis_keep;
    logic [N_SRC-1:0]             s_axis_last;

    logic                         m_axis_valid;
    logic                         m_axis_ready;
    logic [DATA_BITS-1:0]         m_axis_data;
    logic [DATA_BITS/8-1:0]       m_axis_keep;
    logic                         m_axis_last;
    logic [SRC_BITS-1:0]          m_axis_dest;

    // master: the arbiter itself (owns s_axis_ready and the m_axis outputs)
    modport master (
        input  s_axis_valid, s_axis_data, s_axis_keep, s_axis_last, m_axis_ready,
        output s_axis_ready, m_axis_valid, m_axis_data, m_axis_keep, m_axis_last, m_axis_dest
    );

    // slave: the surrounding sources and sink
    modport slave (
        output s_axis_valid, s_axis_data, s_axis_keep, s_axis_last, m_axis_ready,
        input  s_axis_ready, m_axis_valid, m_axis_data, m_axis_keep, m_axis_last, m_axis_dest
    );
endinterface

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter: N_SRC AXI-Stream sources onto one registered output.
// Latency: 1 arbitration cycle per packet, then 1 cycle per beat into the output register.
// Backpressure: m_axis_ready low with a full output register drops s_axis_ready combinationally.
// Ports: aclk/areset (async, active high), axis (stream bundle, master side),
//        src_en (new-grant mask, sampled only in IDLE), busy (in LOCK), grant_id (current/last grant).
module axis_pkt_arbiter #(
    parameter int N_SRC     = 4,
    parameter int DATA_BITS = 512
) (
    input  logic                      aclk,
    input  logic                      areset,
    axis_pkt_arbiter_if.master        axis,
    input  logic [N_SRC-1:0]          src_en,
    output logic                      busy,
    output logic [((N_SRC > 1) ? $clog2(N_SRC) : 1)-1:0] grant_id
);
    localparam int SRC_BITS  = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int KEEP_BITS = DATA_BITS / 8;

    typedef enum logic {IDLE, LOCK} state_t;

    typedef struct packed {
        logic [DATA_BITS-1:0] data;
        logic [KEEP_BITS-1:0] keep;
        logic                 last;
        logic [SRC_BITS-1:0]  dest;
    } beat_t;

    state_t              state_q, state_d;
    logic [SRC_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [SRC_BITS-1:0] grant_q, grant_d;
    logic [SRC_BITS-1:0] winner;
    logic [N_SRC-1:0]    req;
    logic [N_SRC-1:0]    s_rdy;
    logic                found;
    int                  idx;
    logic                out_free;
    logic                accept;
    logic                out_vld_q;
    beat_t               out_q;
    beat_t               in_beat;

    assign req      = axis.s_axis_valid & src_en;
    // Output register can take a beat if empty or draining this cycle.
    assign out_free = !out_vld_q || axis.m_axis_ready;

    // First requester at or after rr_ptr, wrapping.
    always_comb begin
        winner = rr_ptr_q;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = (int'(rr_ptr_q) + k) % N_SRC;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = SRC_BITS'(idx);
            end
        end
    end

    always_comb begin
        in_beat      = '0;
        in_beat.data = axis.s_axis_data[grant_q*DATA_BITS +: DATA_BITS];
        in_beat.keep = axis.s_axis_keep[grant_q*KEEP_BITS +: KEEP_BITS];
        in_beat.last = axis.s_axis_last[grant_q];
        in_beat.dest = grant_q;
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        s_rdy    = '0;
        accept   = 1'b0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = winner;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                // src_en is ignored here so a granted packet always completes.
                s_rdy[grant_q] = out_free;
                accept         = axis.s_axis_valid[grant_q] && out_free;
                if (accept && axis.s_axis_last[grant_q]) begin
                    state_d  = IDLE;
                    rr_ptr_d = (grant_q == SRC_BITS'(N_SRC - 1)) ? '0 : grant_q + SRC_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            // Output register is independent of state so the last beat drains during IDLE.
            if (accept) begin
                out_q     <= in_beat;
                out_vld_q <= 1'b1;
            end else if (axis.m_axis_ready) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign axis.s_axis_ready = s_rdy;
    assign axis.m_axis_valid = out_vld_q;
    assign axis.m_axis_data  = out_q.data;
    assign axis.m_axis_keep  = out_q.keep;
    assign axis.m_axis_last  = out_q.last;
    assign axis.m_axis_dest  = out_q.dest;
    assign busy              = (state_q == LOCK);
    assign grant_id          = grant_q;
endmodule

// File: doc/axis_pkt_arbiter.md
# axis_pkt_arbiter

Packet-level round-robin arbiter that shares a single 512-bit AXI4-Stream datapath, such as a chain of data register stages feeding the TCP/IP transmit path, between N_SRC independent stream sources. A grant is held for a whole packet, from the first beat to the beat with `last`, so packets are never interleaved. The block has a registered output stage and tags each output beat with the winning source index. It sits between the per-session/per-kernel transmit streams and the shared network datapath.

## Interface
Parameters:
- N_SRC, 4, number of requesting sources (1..16)
- DATA_BITS, 512, data width; keep width = DATA_BITS/8
- SRC_BITS, derived = max(1, $clog2(N_SRC)), width of source index

Ports:
- aclk  in  1  sole clock; all logic on rising edge
- areset  in  1  asynchronous, active-high reset
- s_axis_valid  in  N_SRC  per-source valid
- s_axis_ready  out  N_SRC  per-source ready
- s_axis_data  in  N_SRC*DATA_BITS  per-source data, source i at [i*DATA_BITS +: DATA_BITS]
- s_axis_keep  in  N_SRC*DATA_BITS/8  per-source keep
- s_axis_last  in  N_SRC  per-source last
- src_en  in  N_SRC  arbitration enable mask; a source with bit 0 is never newly granted
- m_axis_valid  out  1  output valid (registered)
- m_axis_ready  in  1  output ready
- m_axis_data  out  DATA_BITS  output data
- m_axis_keep  out  DATA_BITS/8  output keep
- m_axis_last  out  1  output last
- m_axis_dest  out  SRC_BITS  source index of the current output beat
- busy  out  1  high while in LOCK state
- grant_id  out  SRC_BITS  currently or most recently granted source

## Operation
- Reset values: m_axis_valid=0, data/keep/last/dest=0, s_axis_ready=0, busy=0, grant_id=0, state=IDLE, rr_ptr=0.
- Request: req[i] = s_axis_valid[i] & src_en[i].
- IDLE state:
  - All s_axis_ready are 0.
  - If any req is set, the winner is the first set req at index rr_ptr, rr_ptr+1, ... wrapping modulo N_SRC.
  - Next edge: grant_id <= winner, state <= LOCK.
  - If no req is set, stay in IDLE.
- LOCK state:
  - s_axis_ready[grant_id] = out_free, where out_free = !m_axis_valid | m_axis_ready. All other readies are 0.
  - Accepted beat (valid & ready on grant_id): the output register loads data, keep, last, and dest=grant_id, and m_axis_valid <= 1.
  - Otherwise, if m_axis_ready, m_axis_valid <= 0.
  - On an accepted beat with last=1: state <= IDLE, and rr_ptr <= (grant_id+1) mod N_SRC, wrapping from N_SRC-1 to 0.
- src_en is sampled only in IDLE. Deasserting src_en for the granted source mid-packet has no effect until that packet's last beat.
- Output register holds its contents stable while m_axis_valid=1 and m_axis_ready=0, per AXI-Stream rules.
- m_axis_valid is not gated by state. The final beat drains in IDLE while the next arbitration proceeds.
- A single-beat packet (last on the first beat) is legal: one beat in LOCK, then IDLE.
- N_SRC=1: the arbiter degenerates to a pass-through with a one-cycle bubble per packet; rr_ptr stays 0.
- Reset mid-packet clears all state. The partial packet in progress is truncated (no last emitted), and the output register is discarded. Upstream and downstream are reset together by system convention.
- The block performs no packet-length or keep checking.

## Timing
- Arbitration: one cycle in IDLE per packet, giving a one-cycle s_ready bubble between packets.
- First-beat latency: valid asserted in cycle 0 (IDLE) → ready in cycle 1 → beat on m_axis in cycle 2.
- In-packet throughput is 1 beat/cycle with m_axis_ready held high. Subsequent beats have 1-cycle latency.
- Sustained throughput with continuous back-to-back packets of L beats is L/(L+1).
- Backpressure: m_axis_ready low with m_axis_valid high forces s_axis_ready low in the same cycle (combinational path from m_axis_ready to s_axis_ready).
- No combinational path from any s_axis input to any m_axis output.

## Test plan
- Single source: src 2 sends a 3-beat packet, data 0xA,0xB,0xC, m_axis_ready=1 → beats appear in cycles 2,3,4 with dest=2 and last only on 0xC; busy high in cycles 1–3.
- Round-robin fairness: all 4 sources continuously send 2-beat packets, all src_en=1 → grant order 0,1,2,3,0,…; no interleaving within a packet; after reset the first grant is 0.
- Mask: src_en=4'b1010 with all sources valid → only 1 and 3 are granted, alternating. Clearing src_en[1] during src 1's packet still completes that packet.
- Backpressure: random m_axis_ready at 50% on 8-beat packets → output data stable while stalled; no beat lost or duplicated; scoreboard matches per-source order.
- Single-beat packets back-to-back from src 0 only → src 0 is re-granted after rr_ptr moves to 1; one bubble cycle between beats.
- Reset mid-packet: assert areset at beat 2 of 5 → m_axis_valid=0, all s_axis_ready=0, busy=0 immediately; after release the first grant goes to the lowest-index requester.
